jtag_register_file: RTL and testbench
=====================================

# jtag_register_file

Register file and DR scan chain behind the virtual JTAG TAP, clocked in the iMAIN_CLK domain. It consumes the TCK/TDI/state signals after they have been synchronized into iMAIN_CLK. It captures a selected register into a shift chain, shifts it out on TDO while shifting in TDI, and commits the shifted word into an output register on Update-DR. It sits directly downstream of the JTAG synchronizer and drives its TDO return path.

## Interface
- NUMBER_OF_REGISTERS, 16, number of readable/writable registers; register k is addressed as k+1.
- REGISTER_SIZE, 32, bits per register and DR chain length.
- ADDRESS_WIDTH, $clog2(NUMBER_OF_REGISTERS+1), derived; address 0 is reserved.
- iMAIN_CLK  in  1  system clock; the only clock.
- iRESET_N  in  1  asynchronous, active-low reset.
- iADDRESS  in  2*ADDRESS_WIDTH+1  IR value. [ADDRESS_WIDTH-1:0] is the read address. [2*ADDRESS_WIDTH-1:ADDRESS_WIDTH] is the write address. [2*ADDRESS_WIDTH] is the write enable.
- iTCK  in  1  synchronized TCK level.
- iTDI  in  1  synchronized TDI.
- iSTATE_CDR / iSTATE_SDR / iSTATE_UDR  in  1 each  synchronized Capture-DR / Shift-DR / Update-DR levels.
- oTDO  out  1  serial data back to the synchronizer.
- iDATA  in  NUMBER_OF_REGISTERS x REGISTER_SIZE  values captured on read.
- oDATA  out  NUMBER_OF_REGISTERS x REGISTER_SIZE  values written from JTAG.
- oWRITE_STROBE  out  NUMBER_OF_REGISTERS  one-cycle pulse, one-hot, marks the register just written.

## Operation
- Edge detect: tck_q registers iTCK.
  - tck_rise = iTCK & ~tck_q.
  - tck_fall = ~iTCK & tck_q.
- All actions below occur on the iMAIN_CLK edge where tck_rise or tck_fall is true.
- Priority on tck_rise when several state inputs are high: CDR > SDR > UDR.
- Capture (tck_rise & CDR):
  - Latch iADDRESS into addr_q.
  - Load shift_reg with the selected value:
    - Read address 0: NUMBER_OF_REGISTERS, zero-extended. This is the discovery word.
    - Read address 1..N: iDATA[addr-1].
    - Read address >N: 0.
- Shift (tck_rise & SDR): shift_reg <= {iTDI, shift_reg[REGISTER_SIZE-1:1]}. The chain is LSB first.
- TDO (tck_fall): oTDO <= shift_reg[0]. oTDO holds between falling edges.
- Update (tck_rise & UDR):
  - If addr_q write enable = 1 and write address is in 1..N:
    - oDATA[waddr-1] <= shift_reg.
    - oWRITE_STROBE[waddr-1] = 1 for exactly one iMAIN_CLK cycle.
  - Otherwise: no write and no strobe.
- Only one write occurs per UDR level, because the write fires on tck_rise only. Holding UDR high over further TCK rises re-commits the same shift_reg value and pulses the strobe again; this matches TAP behaviour, where UDR lasts one TCK.
- Shift counts that are not a multiple of REGISTER_SIZE are legal. Whatever sits in shift_reg at Update is written.
- Address 0 and out-of-range write addresses never modify oDATA.
- Reset values: tck_q=0, shift_reg=0, addr_q=0, oTDO=0, oDATA all 0, oWRITE_STROBE all 0.
- Reset asserted mid-scan clears all state immediately. After release, the next CDR rise starts a fresh capture.

## Timing
- Latency: from iTCK rising as seen at the input, shift_reg/oDATA/oWRITE_STROBE update on the next iMAIN_CLK edge. The same holds for oTDO after an iTCK fall.
- Combined with the upstream 2-FF synchronizer, TDO lags the real TCK falling edge by ≤3 iMAIN_CLK cycles.
- iMAIN_CLK must be ≥4× TCK frequency.
- iADDRESS must be stable from CDR to UDR. It is sampled only at capture.
- iDATA is sampled once, on the capture edge. Later changes do not affect the scan in progress.
- oDATA is registered and glitch-free. oWRITE_STROBE is asserted in the same cycle the new oDATA value first appears.

## Test plan
- Reset: hold iRESET_N=0 with random inputs and TCK toggling. Required: oTDO=0, oDATA all 0, oWRITE_STROBE=0; release produces no spurious strobe.
- Read: N=16, iDATA[2]=0xA5A5_1234, IR read address 3, then CDR + 32 SDR clocks with TDI=0. Required: oTDO serial stream LSB-first equals 0xA5A5_1234.
- Discovery: read address 0, capture + 32 shifts. Required: TDO word = 16. Read address 17 → TDO word 0.
- Write: IR write enable=1, write address 5, shift in 0xDEAD_BEEF, then UDR.
  - Required: oDATA[4]=0xDEAD_BEEF.
  - oWRITE_STROBE=0x0010 for exactly one cycle.
  - All other oDATA unchanged.
- Write blocked: repeat the Write scenario with write enable=0, then with write address 0 and then 17. Required: no oDATA change, no strobe.
- Reset mid-shift: assert reset after 10 shift clocks, release, then do a full read of register 1 with iDATA[0]=0x0000_0001. Required: correct word with no residue from the aborted scan.

Source files
------------

// File: rtl/jtag_register_file.sv
// jtag_register_file
//   Register file and DR scan chain behind the virtual JTAG TAP. Everything
//   runs in the iMAIN_CLK domain; the TCK/TDI/TAP-state inputs have already
//   been synchronized upstream. A scan captures the register selected by the
//   IR read address, shifts it out LSB first on oTDO while TDI shifts in,
//   and commits the shifted word to oDATA on Update-DR.
//
// Ports
//   iMAIN_CLK, iRESET_N   system clock, asynchronous active-low reset
//   iADDRESS              IR value {wr_en, wr_addr, rd_addr}; address 0 reserved
//   iTCK, iTDI            synchronized TCK level and TDI
//   iSTATE_CDR/SDR/UDR    synchronized Capture/Shift/Update-DR levels
//   oTDO                  serial data back to the synchronizer
//   iDATA                 per-register values captured on read
//   oDATA                 per-register values written from JTAG
//   oWRITE_STROBE         one-hot, one-cycle pulse marking the register written

// One output register slot. The address compare is local so each slot
// decides on its own whether an update targets it.
module jtag_register_file_slot #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int SLOT          = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     upd_i,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [REGISTER_SIZE-1:0] wdata_i,
  output logic [REGISTER_SIZE-1:0] data_o,
  output logic                     strobe_o
);
  logic                     hit;
  logic [REGISTER_SIZE-1:0] data_d, data_q;
  logic                     strobe_d, strobe_q;

  // Register k answers to write address k+1.
  assign hit      = upd_i & wr_en_i & (waddr_i == ADDRESS_WIDTH'(SLOT + 1));
  assign data_d   = hit ? wdata_i : data_q;
  assign strobe_d = hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  // Data and strobe come from the same edge, so the strobe marks the
  // first cycle the new value is visible.
  assign data_o   = data_q;
  assign strobe_o = strobe_q;
endmodule

module jtag_register_file #(
  parameter  int NUMBER_OF_REGISTERS = 16,
  parameter  int REGISTER_SIZE       = 32,
  localparam int ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS + 1)
) (
  input  logic                                              iMAIN_CLK,
  input  logic                                              iRESET_N,
  input  logic [2*ADDRESS_WIDTH:0]                          iADDRESS,
  input  logic                                              iTCK,
  input  logic                                              iTDI,
  input  logic                                              iSTATE_CDR,
  input  logic                                              iSTATE_SDR,
  input  logic                                              iSTATE_UDR,
  output logic                                              oTDO,
  input  logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] iDATA,
  output logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0] oDATA,
  output logic [NUMBER_OF_REGISTERS-1:0]                    oWRITE_STROBE
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int RS = REGISTER_SIZE;

  logic                 tck_q;
  logic                 tck_rise, tck_fall;
  logic                 do_cap, do_shift, do_upd;
  logic [AW-1:0]        raddr;
  logic [RS-1:0]        cap_word;
  logic [RS-1:0]        shift_d, shift_q;
  logic [2*AW:0]        addr_d, addr_q;
  logic                 tdo_d, tdo_q;

  assign tck_rise = iTCK & ~tck_q;
  assign tck_fall = ~iTCK & tck_q;

  // State priority on a TCK rise: capture, then shift, then update.
  assign do_cap   = tck_rise & iSTATE_CDR;
  assign do_shift = tck_rise & ~iSTATE_CDR & iSTATE_SDR;
  assign do_upd   = tck_rise & ~iSTATE_CDR & ~iSTATE_SDR & iSTATE_UDR;

  assign raddr = iADDRESS[AW-1:0];

  // Capture mux: address 0 returns the register count (discovery word),
  // out-of-range addresses read as zero.
  always_comb begin
    cap_word = '0;
    if (raddr == '0) cap_word = RS'(NUMBER_OF_REGISTERS);
    for (int k = 0; k < NUMBER_OF_REGISTERS; k++) begin
      if (raddr == AW'(k + 1)) cap_word = iDATA[k];
    end
  end

  always_comb begin
    shift_d = shift_q;
    addr_d  = addr_q;
    tdo_d   = tdo_q;
    if (do_cap) begin
      shift_d = cap_word;
      addr_d  = iADDRESS;
    end else if (do_shift) begin
      shift_d = {iTDI, shift_q[RS-1:1]};  // LSB leaves first
    end
    if (tck_fall) tdo_d = shift_q[0];
  end

  always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      tck_q   <= 1'b0;
      shift_q <= '0;
      addr_q  <= '0;
      tdo_q   <= 1'b0;
    end else begin
      tck_q   <= iTCK;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      tdo_q   <= tdo_d;
    end
  end

  assign oTDO = tdo_q;

  // Writes use the address latched at capture, not the live IR.
  for (genvar g = 0; g < NUMBER_OF_REGISTERS; g++) begin : g_slot
    jtag_register_file_slot #(
      .REGISTER_SIZE(RS),
      .ADDRESS_WIDTH(AW),
      .SLOT         (g)
    ) u_slot (
      .clk_i   (iMAIN_CLK),
      .rst_ni  (iRESET_N),
      .upd_i   (do_upd),
      .wr_en_i (addr_q[2*AW]),
      .waddr_i (addr_q[2*AW-1:AW]),
      .wdata_i (shift_q),
      .data_o  (oDATA[g]),
      .strobe_o(oWRITE_STROBE[g])
    );
  end
endmodule

// File: tb/tb_jtag_register_file.sv
module tb_jtag_register_file;
  localparam int N  = 16;
  localparam int RS = 32;
  localparam int AW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [2*AW:0]          iaddr;
  logic                   tck, tdi, cdr, sdr, udr;
  logic                   tdo;
  logic [N-1:0][RS-1:0]   idata, odata;
  logic [N-1:0]           stb;

  always #5 clk = ~clk;

  jtag_register_file dut (
    .iMAIN_CLK    (clk),
    .iRESET_N     (rst_n),
    .iADDRESS     (iaddr),
    .iTCK         (tck),
    .iTDI         (tdi),
    .iSTATE_CDR   (cdr),
    .iSTATE_SDR   (sdr),
    .iSTATE_UDR   (udr),
    .oTDO         (tdo),
    .iDATA        (idata),
    .oDATA        (odata),
    .oWRITE_STROBE(stb)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [RS-1:0] model [N];

  // Strobe monitor: counts strobe cycles and remembers the last pattern.
  int            stb_total = 0;
  logic [N-1:0]  stb_last  = '0;
  always @(posedge clk) begin
    #1;
    if (|stb) begin
      stb_total++;
      stb_last = stb;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_odata(input string nm);
    for (int k = 0; k < N; k++) chk($sformatf("%s_odata[%0d]", nm, k), odata[k], model[k]);
  endtask

  // Expected capture word straight from the addressing rules.
  function automatic logic [31:0] exp_read(input int ra);
    if (ra == 0) return 32'(N);
    if (ra <= N) return idata[ra-1];
    return 32'h0;
  endfunction

  // One full TCK period: 4 main clocks high, 4 low.
  task automatic tck_cyc(input logic d, input logic c, input logic s, input logic u);
    @(negedge clk);
    tdi = d; cdr = c; sdr = s; udr = u; tck = 1'b1;
    repeat (4) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
    cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
  endtask

  // Capture, nsh shifts of din, then nupd update rises. TDO word valid for nsh>=31.
  task automatic scan(input int ra, input int wa, input bit we, input logic [31:0] din,
                      input int nsh, input int nupd, input bit perturb,
                      output logic [31:0] w);
    logic [N-1:0][RS-1:0] saved;
    w = '0;
    iaddr = {we, AW'(wa), AW'(ra)};
    tck_cyc(1'b0, 1'b1, 1'b0, 1'b0);
    w[0] = tdo;
    saved = idata;
    if (perturb) idata = ~idata;
    for (int i = 0; i < nsh; i++) begin
      tck_cyc(din[i], 1'b0, 1'b1, 1'b0);
      if (i < 31) w[i+1] = tdo;
    end
    idata = saved;
    for (int i = 0; i < nupd; i++) tck_cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic void model_write(input int wa, input bit we, input logic [31:0] v);
    if (we && wa >= 1 && wa <= N) model[wa-1] = v;
  endfunction

  typedef struct {
    int          ra;
    int          wa;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] exp_tdo;
    logic [15:0] exp_stb;
  } vec_t;

  vec_t          tbl [8];
  logic [31:0]   w, exp_w, v;
  int            s0, ra, wa;
  bit            we;

  initial begin
    tbl[0] = '{3,  0,  1'b0, 32'h0,         32'hA5A5_1234, 16'h0000};
    tbl[1] = '{0,  0,  1'b0, 32'h0,         32'h0000_0010, 16'h0000};
    tbl[2] = '{17, 0,  1'b0, 32'h0,         32'h0000_0000, 16'h0000};
    tbl[3] = '{0,  5,  1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 16'h0010};
    tbl[4] = '{5,  5,  1'b0, 32'h1234_5678, 32'h5A00_0004, 16'h0000};
    tbl[5] = '{16, 0,  1'b1, 32'hCAFE_F00D, 32'h5A00_000F, 16'h0000};
    tbl[6] = '{31, 17, 1'b1, 32'h0BAD_F00D, 32'h0000_0000, 16'h0000};
    tbl[7] = '{1,  16, 1'b1, 32'h600D_C0DE, 32'h5A00_0000, 16'h8000};

    for (int k = 0; k < N; k++) model[k] = '0;

    // Reset held with random activity on every input.
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {tck, tdi, cdr, sdr, udr} = 5'($urandom);
      iaddr = 11'($urandom);
      for (int k = 0; k < N; k++) idata[k] = $urandom;
      @(posedge clk); #1;
      chk("rst_tdo", 32'(tdo), 32'h0);
      chk("rst_stb", 32'(stb), 32'h0);
      chk("rst_odata_or", 32'(|odata), 32'h0);
    end
    @(negedge clk);
    {tck, tdi, cdr, sdr, udr} = '0;
    iaddr = '0;
    for (int k = 0; k < N; k++) idata[k] = 32'h5A00_0000 | 32'(k);
    idata[2] = 32'hA5A5_1234;
    s0 = stb_total;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rel_no_strobe", 32'(stb_total - s0), 32'h0);

    // Directed table.
    for (int t = 0; t < 8; t++) begin
      s0 = stb_total;
      scan(tbl[t].ra, tbl[t].wa, tbl[t].we, tbl[t].wdata, 32, 1, 1'b0, w);
      chk($sformatf("tbl%0d_tdo", t), w, tbl[t].exp_tdo);
      chk($sformatf("tbl%0d_stb_cycles", t), 32'(stb_total - s0), (tbl[t].exp_stb != 0) ? 32'h1 : 32'h0);
      if (tbl[t].exp_stb != 0) chk($sformatf("tbl%0d_stb", t), 32'(stb_last), 32'(tbl[t].exp_stb));
      model_write(tbl[t].wa, tbl[t].we, tbl[t].wdata);
      chk_odata($sformatf("tbl%0d", t));
    end

    // Partial shift: 8 bits in, upper 24 bits of captured word move down.
    scan(3, 2, 1'b1, 32'h0000_00C3, 8, 1, 1'b0, w);
    model_write(2, 1'b1, 32'hC3A5_A512);
    chk_odata("partial");

    // UDR held across two TCK rises commits twice.
    s0 = stb_total;
    scan(0, 9, 1'b1, 32'h1357_9BDF, 32, 2, 1'b0, w);
    model_write(9, 1'b1, 32'h1357_9BDF);
    chk("udr_hold_cycles", 32'(stb_total - s0), 32'h2);
    chk("udr_hold_stb", 32'(stb_last), 32'h0000_0100);
    chk_odata("udr_hold");

    // CDR wins over SDR and UDR even with a valid write pending in addr_q.
    scan(0, 5, 1'b1, 32'h7777_7777, 32, 0, 1'b0, w);
    s0 = stb_total;
    tck_cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("prio_no_strobe", 32'(stb_total - s0), 32'h0);
    chk_odata("prio");

    // iDATA changing after capture does not disturb the scan.
    scan(4, 0, 1'b0, 32'h0, 32, 0, 1'b1, w);
    chk("idata_sampled_once", w, 32'h5A00_0003);

    // Randomized scans against the model.
    for (int i = 0; i < 30; i++) begin
      ra = int'($urandom_range(0, 31));
      wa = int'($urandom_range(0, 31));
      we = 1'($urandom);
      v  = $urandom;
      exp_w = exp_read(ra);
      s0 = stb_total;
      scan(ra, wa, we, v, 32, 1, 1'b0, w);
      chk($sformatf("rnd%0d_tdo ra=%0d", i, ra), w, exp_w);
      if (we && wa >= 1 && wa <= N) begin
        chk($sformatf("rnd%0d_stb_cycles", i), 32'(stb_total - s0), 32'h1);
        chk($sformatf("rnd%0d_stb", i), 32'(stb_last), 32'(1) << (wa - 1));
      end else begin
        chk($sformatf("rnd%0d_stb_cycles", i), 32'(stb_total - s0), 32'h0);
      end
      model_write(wa, we, v);
      chk_odata($sformatf("rnd%0d", i));
    end

    // Reset in the middle of a shift, then a clean read of register 1.
    idata[0] = 32'h0000_0001;
    iaddr = {1'b0, AW'(0), AW'(1)};
    tck_cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_cyc(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    sdr = 1'b1; tck = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < N; k++) model[k] = '0;
    #1;
    chk("midrst_tdo", 32'(tdo), 32'h0);
    chk_odata("midrst");
    repeat (3) @(negedge clk);
    tck = 1'b0; sdr = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    scan(1, 0, 1'b0, 32'h0, 32, 0, 1'b0, w);
    chk("midrst_read", w, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
